pea_ctrl: RTL

- Run-time controller for the 4x4 processing-element array (PEA).
- Accepts one 32-bit configuration word per PE over a valid/ready stream into a shadow bank, then commits the shadow bank to the active bank on start.
- Sequences a programmed number of issue cycles with stall handling, drains the PE pipeline, and reports completion.
- Shadow/active double-buffering lets the next kernel's configuration load while the current kernel runs.

---
 rtl/pea_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pea_ctrl.sv
// pea_ctrl: run-time controller for the MxN PE array with shadow/active config banks.
// Optional perf counters are built only when PEA_CTRL_PERF_EN is defined.
module pea_ctrl #(
    parameter int M            = 4,
    parameter int N            = 4,
    parameter int N_CFG_BITS   = 32,
    parameter int ITER_W       = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic [N_CFG_BITS-1:0]          cfg_data_i,
    input  logic                           cfg_clear_i,
    output logic                           cfg_full_o,
    input  logic                           start_i,
    input  logic [ITER_W-1:0]              iter_count_i,
    input  logic                           abort_i,
    input  logic                           stall_i,
    output logic [M*N*N_CFG_BITS-1:0]      pe_cfg_o,
    output logic                           pea_en_o,
    output logic                           issue_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [31:0]                    run_cycles_o,
    output logic [31:0]                    stall_cycles_o
);
    localparam int NW = M * N;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                     r_state;
    logic [N_CFG_BITS-1:0]      r_shadow [NW];
    logic [NW*N_CFG_BITS-1:0]   r_active;
    logic [CW-1:0]              r_word_cnt;
    logic                       r_full;
    logic                       r_init;
    logic                       r_done;
    logic                       r_err;
    logic                       r_busy;
    logic [ITER_W-1:0]          r_iter_left;
    logic [3:0]                 r_drain_cnt;
    logic [NW*N_CFG_BITS-1:0]   w_shadow_flat;
    logic                       w_accept;
    logic                       w_commit;
    logic                       w_last_word;

    // r_init holds ready low until the first edge after reset release
    assign cfg_ready_o = r_init && !r_full && !cfg_clear_i;
    assign w_accept    = cfg_valid_i && cfg_ready_o;
    assign w_last_word = r_word_cnt == CW'(NW - 1);
    assign w_commit    = (r_state == IDLE) && start_i && r_full && !abort_i;
    assign cfg_full_o  = r_full;
    assign pe_cfg_o    = r_active;
    assign pea_en_o    = (r_state != IDLE) && !stall_i;
    assign issue_o     = (r_state == RUN) && !stall_i;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;

    // flatten the shadow bank so a commit is a single wide copy, PE0 in LSBs
    always_comb begin
        w_shadow_flat = '0;
        for (int i = 0; i < NW; i++)
            w_shadow_flat[i*N_CFG_BITS +: N_CFG_BITS] = r_shadow[i];
    end

    // shadow bank: accepted words land at the current arrival index
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NW; i++)
                r_shadow[i] <= '0;
        end else if (w_accept) begin
            r_shadow[r_word_cnt] <= cfg_data_i;
        end
    end

    // word counter and full flag; clear and commit both empty the shadow bank
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_init     <= 1'b0;
            r_word_cnt <= '0;
            r_full     <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (cfg_clear_i || w_commit) begin
                r_word_cnt <= '0;
                r_full     <= 1'b0;
            end else if (w_accept) begin
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + CW'(1);
                r_full     <= w_last_word;
            end
        end
    end

    // active bank only changes on a committed start
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_active <= '0;
        else if (w_commit)
            r_active <= w_shadow_flat;
    end

    // kernel sequencer: issue phase, drain phase, single-cycle done/err pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_iter_left <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (abort_i) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start_i && r_full) begin
                            r_iter_left <= iter_count_i;
                            if (iter_count_i != '0) begin
                                r_state <= RUN;
                                r_busy  <= 1'b1;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end else if (start_i) begin
                            r_err <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!stall_i) begin
                            r_iter_left <= r_iter_left - ITER_W'(1);
                            if (r_iter_left == ITER_W'(1)) begin
                                if (DRAIN_CYCLES > 0) begin
                                    r_state     <= DRAIN;
                                    r_drain_cnt <= 4'(DRAIN_CYCLES);
                                end else begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        if (!stall_i) begin
                            r_drain_cnt <= r_drain_cnt - 4'd1;
                            if (r_drain_cnt == 4'd1) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PEA_CTRL_PERF_EN
    logic [31:0] r_run_cycles;
    logic [31:0] r_stall_cycles;

    // saturating perf counters, cleared on commit, frozen while idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run_cycles   <= '0;
            r_stall_cycles <= '0;
        end else if (w_commit) begin
            r_run_cycles   <= '0;
            r_stall_cycles <= '0;
        end else if (r_state != IDLE) begin
            r_run_cycles   <= r_run_cycles + {31'd0, ~&r_run_cycles};
            r_stall_cycles <= r_stall_cycles + {31'd0, stall_i && ~&r_stall_cycles};
        end
    end

    assign run_cycles_o   = r_run_cycles;
    assign stall_cycles_o = r_stall_cycles;
`else
    assign run_cycles_o   = '0;
    assign stall_cycles_o = '0;
`endif

endmodule
